// File: rtl/sprite_plot_scheduler.sv
// sprite_plot_scheduler
//   Shares the single VGA plot port among NUM_SPRITES sprite drawers. Each
//   frame tick starts an erase pass over every active sprite, followed by a
//   draw pass. The granted sprite owns the plot port until it reports done.
//
//   Optional build macro: SCHED_WATCHDOG_EN adds a per-grant watchdog of
//   WDOG_CYCLES cycles and drives the sticky timeout_err flag. Without it,
//   timeout_err is tied low and a grant waits for done indefinitely.
//
//   Ports
//     CLOCK_50, reset             clock, asynchronous active-low reset
//     frame_tick                  start a new frame sequence (pulse)
//     spr_active                  per-sprite participation, latched at tick
//     spr_x/spr_y/spr_colour      packed per-sprite pixel fields
//     spr_pix_valid, spr_done     per-sprite pixel strobe and done level
//     spr_start                   one-hot start pulse to the granted sprite
//     spr_erase                   erase pass in progress
//     vga_x/vga_y/vga_colour/vga_plot  muxed plot port to vga_adapter
//     busy                        a sequence is in progress
//     frame_overrun               tick arrived while busy (pulse)
//     timeout_err                 sticky watchdog flag
module sprite_plot_scheduler #(
   parameter int unsigned NUM_SPRITES  = 4,
   parameter logic [2:0]  ERASE_COLOUR = 3'b000,
   parameter int unsigned WDOG_CYCLES  = 1023
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic [NUM_SPRITES-1:0]   spr_active,
   input  logic [8*NUM_SPRITES-1:0] spr_x,
   input  logic [7*NUM_SPRITES-1:0] spr_y,
   input  logic [3*NUM_SPRITES-1:0] spr_colour,
   input  logic [NUM_SPRITES-1:0]   spr_pix_valid,
   input  logic [NUM_SPRITES-1:0]   spr_done,
   output logic [NUM_SPRITES-1:0]   spr_start,
   output logic                     spr_erase,
   output logic [7:0]               vga_x,
   output logic [6:0]               vga_y,
   output logic [2:0]               vga_colour,
   output logic                     vga_plot,
   output logic                     busy,
   output logic                     frame_overrun,
   output logic                     timeout_err
);

   localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_START, ST_WAIT} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic                   phase_draw;
   logic [NUM_SPRITES-1:0] mask;
   logic                   first_wait;
   logic                   wdog_hit;
   logic                   done_ok;
   logic                   advance;
   int unsigned            sel;

   assign sel = 32'(idx);

   // Done is only honoured after the first WAIT cycle so a level left over
   // from the sprite's previous grant cannot end the new grant early.
   assign done_ok = (state == ST_WAIT) && !first_wait && spr_done[idx];
   assign advance = ((state == ST_SCAN) && !mask[idx]) || done_ok ||
                    ((state == ST_WAIT) && wdog_hit);

   // Sequencer: scan sprites in index order, erase pass then draw pass.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         phase_draw <= 1'b0;
         mask       <= '0;
         first_wait <= 1'b0;
         spr_start  <= '0;
         spr_erase  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         spr_start <= '0;
         case (state)
            ST_IDLE: begin
               if (frame_tick) begin
                  mask       <= spr_active;
                  idx        <= '0;
                  phase_draw <= 1'b0;
                  state      <= ST_SCAN;
                  busy       <= 1'b1;
                  spr_erase  <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (mask[idx]) begin
                  state     <= ST_START;
                  spr_start <= NUM_SPRITES'(1) << idx;
               end
            end
            ST_START: begin
               state      <= ST_WAIT;
               first_wait <= 1'b1;
            end
            ST_WAIT: begin
               first_wait <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase

         if (advance) begin
            if (idx != LAST_IDX) begin
               idx   <= idx + 1'b1;
               state <= ST_SCAN;
            end else if (!phase_draw) begin
               phase_draw <= 1'b1;
               idx        <= '0;
               state      <= ST_SCAN;
               spr_erase  <= 1'b0;
            end else begin
               phase_draw <= 1'b0;
               state      <= ST_IDLE;
               busy       <= 1'b0;
               spr_erase  <= 1'b0;
            end
         end
      end
   end

   // Plot port mux: only the granted sprite reaches vga_adapter.
   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      if (state == ST_WAIT) begin
         vga_x      = spr_x[8*sel +: 8];
         vga_y      = spr_y[7*sel +: 7];
         vga_colour = phase_draw ? spr_colour[3*sel +: 3] : ERASE_COLOUR;
         vga_plot   = spr_pix_valid[idx];
      end
   end

   assign frame_overrun = frame_tick & busy;

`ifdef SCHED_WATCHDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

   logic [WDOG_W-1:0] wdog_cnt;

   // Counts WAIT cycles of the current grant; the count equals the number
   // of WAIT cycles already completed.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         wdog_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == ST_START)
            wdog_cnt <= '0;
         else if (state == ST_WAIT)
            wdog_cnt <= wdog_cnt + 1'b1;
         if ((state == ST_WAIT) && wdog_hit && !done_ok)
            timeout_err <= 1'b1;
      end
   end

   assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
   assign wdog_hit    = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Testbench for sprite_plot_scheduler: bench-side sprite drawers, a
// procedural reference model of the frame sequence, per-cycle comparison of
// every output, plus directed scenarios with hand-computed expectations.
module tb_sprite_plot_scheduler;

   localparam int NS = 4;
   localparam int WD = 16;

   logic            CLOCK_50 = 1'b0;
   logic            reset = 1'b0;
   logic            frame_tick = 1'b0;
   logic [NS-1:0]   spr_active = '0;
   logic [8*NS-1:0] spr_x = '0;
   logic [7*NS-1:0] spr_y = '0;
   logic [3*NS-1:0] spr_colour = '0;
   logic [NS-1:0]   spr_pix_valid = '0;
   logic [NS-1:0]   spr_done = '1;
   logic [NS-1:0]   spr_start;
   logic            spr_erase;
   logic [7:0]      vga_x;
   logic [6:0]      vga_y;
   logic [2:0]      vga_colour;
   logic            vga_plot;
   logic            busy;
   logic            frame_overrun;
   logic            timeout_err;

   sprite_plot_scheduler #(
      .NUM_SPRITES (NS),
      .ERASE_COLOUR(3'b000),
      .WDOG_CYCLES (WD)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .spr_active   (spr_active),
      .spr_x        (spr_x),
      .spr_y        (spr_y),
      .spr_colour   (spr_colour),
      .spr_pix_valid(spr_pix_valid),
      .spr_done     (spr_done),
      .spr_start    (spr_start),
      .spr_erase    (spr_erase),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .busy         (busy),
      .frame_overrun(frame_overrun),
      .timeout_err  (timeout_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int errors = 0;
   int checks = 0;

   // ---------------- sprite drawer models ----------------
   int          npix [NS];
   bit          lag [NS];
   bit          stuck [NS];
   bit          fixcol_en [NS];
   logic [2:0]  fixcol [NS];
   bit          run [NS];
   bit          hold [NS];
   int          rem [NS];
   logic [NS-1:0] st_seen = '0;

   always @(negedge CLOCK_50) st_seen = spr_start;

   initial begin : drawers
      for (int i = 0; i < NS; i++) begin
         npix[i] = 2; lag[i] = 0; stuck[i] = 0; fixcol_en[i] = 0;
         fixcol[i] = 3'b000; run[i] = 0; hold[i] = 0; rem[i] = 0;
      end
      forever begin
         @(posedge CLOCK_50);
         #1;
         for (int i = 0; i < NS; i++) begin
            if (!reset) run[i] = 1'b0;
            else if (st_seen[i]) begin
               run[i] = 1'b1; rem[i] = npix[i]; hold[i] = lag[i];
            end
            spr_x[8*i +: 8]      = 8'($urandom);
            spr_y[7*i +: 7]      = 7'($urandom);
            spr_colour[3*i +: 3] = fixcol_en[i] ? fixcol[i] : 3'($urandom);
            if (!run[i]) spr_pix_valid[i] = 1'($urandom);
            else if (hold[i]) begin
               hold[i] = 1'b0; spr_pix_valid[i] = 1'b0;   // done still stale
            end else if (stuck[i]) begin
               spr_done[i] = 1'b0; spr_pix_valid[i] = 1'($urandom);
            end else if (rem[i] == 0) begin
               spr_done[i] = 1'b1; run[i] = 1'b0; spr_pix_valid[i] = 1'b0;
            end else begin
               spr_done[i] = 1'b0;
               spr_pix_valid[i] = ($urandom_range(0, 3) != 0);
               if (spr_pix_valid[i]) rem[i]--;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic          e_busy = 0, e_erase = 0, e_wait = 0, e_timeout = 0;
   logic [NS-1:0] e_start = '0;
   int            e_idx = 0;
   bit            abort = 0, rst_evt = 0;

   always @(negedge reset) begin
      rst_evt = 1; e_busy = 0; e_erase = 0; e_wait = 0; e_start = '0; e_timeout = 0;
   end

   task automatic step();
      @(posedge CLOCK_50);
      if (rst_evt || !reset) abort = 1;
      rst_evt = 0;
   endtask

   // One frame: for each pass and sprite one scan cycle; active sprites add
   // a start cycle and wait cycles until a done seen from the 2nd wait on.
   task automatic run_frame(input logic [NS-1:0] m);
      int n;
      abort = 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NS; i++) begin
            e_busy = 1; e_erase = (p == 0); e_start = '0; e_wait = 0;
            step(); if (abort) return;
            if (m[i]) begin
               e_start = '0; e_start[i] = 1'b1;
               step(); if (abort) return;
               e_start = '0; e_wait = 1; e_idx = i; n = 0;
               forever begin
                  step(); if (abort) return;
                  n++;
                  if (n >= 2 && spr_done[i]) break;
`ifdef SCHED_WATCHDOG_EN
                  if (n == WD) begin e_timeout = 1; break; end
`endif
               end
               e_wait = 0;
            end
         end
      end
      e_busy = 0; e_erase = 0; e_start = '0; e_wait = 0;
   endtask

   initial begin : model
      forever begin
         @(posedge CLOCK_50);
         rst_evt = 0;
         if (reset && frame_tick) run_frame(spr_active);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLOCK_50) begin
      logic [26:0] got, exp;
      logic [7:0] ex; logic [6:0] ey; logic [2:0] ec; logic ep;
      ex = '0; ey = '0; ec = '0; ep = 1'b0;
      if (e_wait) begin
         ex = spr_x[8*e_idx +: 8];
         ey = spr_y[7*e_idx +: 7];
         ec = e_erase ? 3'b000 : spr_colour[3*e_idx +: 3];
         ep = spr_pix_valid[e_idx];
      end
      if (!reset) exp = '0;
      else exp = {e_busy, e_erase, e_start, ex, ey, ec, ep, frame_tick & e_busy, e_timeout};
      got = {busy, spr_erase, spr_start, vga_x, vga_y, vga_colour, vga_plot, frame_overrun, timeout_err};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, got, exp);
      end
   end

   // ---------------- activity monitor ----------------
   int plots, erase_plots, erase_nonzero, draw_110, overruns, busy_cycles;
   int slog[$];

   always @(negedge CLOCK_50) begin
      if (vga_plot) begin
         plots++;
         if (spr_erase) begin
            erase_plots++;
            if (vga_colour != 3'b000) erase_nonzero++;
         end else if (vga_colour == 3'b110) draw_110++;
      end
      if (frame_overrun) overruns++;
      if (busy) busy_cycles++;
      for (int i = 0; i < NS; i++)
         if (spr_start[i]) slog.push_back(i + (spr_erase ? 10 : 0));
   end

   task automatic clr();
      plots = 0; erase_plots = 0; erase_nonzero = 0; draw_110 = 0;
      overruns = 0; busy_cycles = 0; slog.delete();
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin cyc(1); n++; end
      chk(name, int'(busy), 0);
   endtask

   function automatic int slog_at(input int k);
      return (slog.size() > k) ? slog[k] : -1;
   endfunction

   initial begin : main
      int n;
      clr();
      cyc(3);
      chk("reset_busy", int'(busy), 0);
      chk("reset_start", int'(spr_start), 0);
      chk("reset_plot", int'(vga_plot), 0);
      reset = 1'b1;
      cyc(4);
      chk("idle_after_release", int'(busy), 0);

      // two active sprites, 13 pixels each
      for (int i = 0; i < NS; i++) begin npix[i] = 13; lag[i] = 0; end
      fixcol_en[0] = 1; fixcol[0] = 3'b110;
      fixcol_en[2] = 1; fixcol[2] = 3'b011;
      clr();
      spr_active = 4'b0101;
      tick();
      wait_idle("t2_idle", 2000);
      chk("t2_plots", plots, 52);
      chk("t2_erase_plots", erase_plots, 26);
      chk("t2_erase_colour", erase_nonzero, 0);
      chk("t2_draw_110", draw_110, 13);
      chk("t2_start_count", slog.size(), 4);
      chk("t2_start0", slog_at(0), 10);
      chk("t2_start1", slog_at(1), 12);
      chk("t2_start2", slog_at(2), 0);
      chk("t2_start3", slog_at(3), 2);
      fixcol_en[0] = 0; fixcol_en[2] = 0;

      // empty mask
      cyc(2); clr();
      spr_active = 4'b0000;
      tick();
      wait_idle("t3_idle", 100);
      chk("t3_busy_cycles", busy_cycles, 8);
      chk("t3_starts", slog.size(), 0);
      chk("t3_plots", plots, 0);

      // tick while sprite 0 is drawing
      cyc(2); clr();
      spr_active = 4'b0001;
      tick(); cyc(4);
      tick();
      wait_idle("t4_idle", 2000);
      chk("t4_overruns", overruns, 1);
      chk("t4_starts", slog.size(), 2);
      cyc(10);
      chk("t4_still_idle", int'(busy), 0);
      chk("t4_no_restart", slog.size(), 2);

      // tick in the cycle the sequence returns to idle
      clr();
      spr_active = 4'b0000;
      tick(); cyc(7);
      tick();
      chk("t4b_idle", int'(busy), 0);
      chk("t4b_overrun", overruns, 1);
      cyc(5);
      chk("t4b_no_restart", int'(busy), 0);

      // stale done held by sprite 1 into its first wait cycle
      clr();
      npix[1] = 3; lag[1] = 1;
      spr_active = 4'b0010;
      tick();
      wait_idle("t5_idle", 500);
      chk("t5_plots", plots, 6);
      lag[1] = 0;

      // reset in the middle of sprite 2's grant
      cyc(2); clr();
      npix[0] = 4; stuck[2] = 1;
      spr_active = 4'b0101;
      tick();
      n = 0;
      while (!spr_start[2] && n < 300) begin cyc(1); n++; end
      chk("t1_grant2_seen", int'(spr_start[2]), 1);
      cyc(3);
      #5 reset = 1'b0;
      #1;
      chk("t1_busy", int'(busy), 0);
      chk("t1_plot", int'(vga_plot), 0);
      chk("t1_start", int'(spr_start), 0);
      stuck[2] = 0;
      cyc(2);
      reset = 1'b1;
      cyc(6);
      chk("t1_idle_after", int'(busy), 0);

      // sprite 3 never finishes
      clr();
      stuck[3] = 1;
      spr_active = 4'b1000;
      tick();
      cyc(60);
`ifdef SCHED_WATCHDOG_EN
      chk("t6_busy", int'(busy), 0);
      chk("t6_timeout", int'(timeout_err), 1);
      cyc(10);
      chk("t6_timeout_sticky", int'(timeout_err), 1);
`else
      chk("t6_busy", int'(busy), 1);
      chk("t6_timeout", int'(timeout_err), 0);
`endif
      stuck[3] = 0;
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(2);
      chk("t6_timeout_cleared", int'(timeout_err), 0);

      // randomized frames with mid-sequence ticks and mask changes
      for (int f = 0; f < 150; f++) begin
         for (int i = 0; i < NS; i++) begin
            npix[i] = $urandom_range(0, 6);
            lag[i]  = 1'($urandom);
         end
         spr_active = 4'($urandom);
         tick();
         n = 0;
         while (busy && n < 3000) begin
            spr_active = 4'($urandom);
            frame_tick = ($urandom_range(0, 15) == 0);
            cyc(1); n++;
         end
         frame_tick = 1'b0;
         chk("rand_idle", int'(busy), 0);
         cyc($urandom_range(0, 3));
      end

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : guard
      #5000000;
      $display("FAIL global_timeout reached t=%0t", $time);
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/sprite_plot_scheduler.md
Name: sprite_plot_scheduler

Overview:
- Sequences the single VGA plot port among NUM_SPRITES sprite drawers (birds, hunter crosshair).
- On each frame tick it runs two passes: an erase pass over every active sprite, then a draw pass.
- Each sprite gets exclusive use of the plot port until it reports done.
- Sits between frame_counter (tick source), the per-sprite drawers, and vga_adapter (x/y/colour/plot).

Parameters:
- NUM_SPRITES, 4, number of requesters (1..8).
- ERASE_COLOUR, 3'b000, colour forced onto vga_colour during the erase pass.
- WDOG_CYCLES, 1023, watchdog limit in cycles per sprite grant (used only with SCHED_WATCHDOG_EN).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse: start a new frame sequence.
- spr_active  in  NUM_SPRITES  sprite i takes part in this frame; latched at tick.
- spr_x  in  8*NUM_SPRITES  pixel x of sprite i at [8i+7:8i].
- spr_y  in  7*NUM_SPRITES  pixel y of sprite i at [7i+6:7i].
- spr_colour  in  3*NUM_SPRITES  pixel colour of sprite i at [3i+2:3i].
- spr_pix_valid  in  NUM_SPRITES  sprite i is presenting a valid pixel this cycle.
- spr_done  in  NUM_SPRITES  sprite i has finished its pixel list (level).
- spr_start  out  NUM_SPRITES  one-hot, one-cycle start pulse to sprite i.
- spr_erase  out  1  1 during the erase pass; the sprite uses its old position.
- vga_x  out  8  muxed x.
- vga_y  out  7  muxed y.
- vga_colour  out  3  muxed colour.
- vga_plot  out  1  write strobe to vga_adapter.
- busy  out  1  a sequence is in progress.
- frame_overrun  out  1  one-cycle pulse: tick arrived while busy.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset state: IDLE, idx=0, phase=ERASE, mask=0. All outputs 0.
- Reset is asynchronous, takes effect mid-sequence, and aborts immediately. No partial state survives.
- State IDLE:
  - frame_tick=1 → mask<=spr_active, idx<=0, phase<=ERASE, go to SCAN.
- State SCAN:
  - mask[idx]=1 → START.
  - mask[idx]=0 → ADVANCE.
- State START:
  - spr_start[idx]=1 for exactly this cycle, then WAIT.
- State WAIT:
  - vga_x/y = sprite idx fields.
  - vga_colour = ERASE_COLOUR if phase=ERASE, else spr_colour[idx].
  - vga_plot = spr_pix_valid[idx].
  - spr_done[idx]=1 → ADVANCE.
  - spr_done is ignored in START and in the first WAIT cycle, so a stale done from the previous grant is not honoured.
- ADVANCE (a transition, not a state; taken from SCAN or WAIT):
  - idx<NUM_SPRITES-1 → idx+1, go to SCAN.
  - Else if phase=ERASE → phase<=DRAW, idx<=0, go to SCAN.
  - Else → IDLE.
- Outputs outside WAIT: vga_x, vga_y, vga_colour and vga_plot are all 0.
- busy = (state != IDLE).
- spr_erase = busy & (phase==ERASE).
- Overhead per frame: 1 SCAN cycle per sprite per pass, plus 1 START cycle and at least 2 WAIT cycles per active sprite per pass.
- Empty mask: exactly 2*NUM_SPRITES SCAN cycles, then IDLE. No start pulses, no plots.
- frame_tick while busy: ignored for sequencing; frame_overrun=1 for that cycle.
- frame_tick in the same cycle that the FSM returns to IDLE: ignored, and flagged as overrun.
- spr_active changes mid-sequence: no effect until the next tick.
- spr_pix_valid from non-granted sprites: ignored.
- Only one spr_start bit is ever high at a time.

Optional Feature:
- Macro SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches WDOG_CYCLES without done, the FSM takes ADVANCE and timeout_err<=1.
  - timeout_err stays set until reset.
- Undefined:
  - No counter is built; timeout_err is tied to 0.
  - WAIT waits for done indefinitely.

Test Plan:
1. Reset mid-WAIT (reset=0 while spr_start history shows grant 2) → same cycle: busy=0, vga_plot=0, spr_start=0. After release, idle until the next tick.
2. NUM_SPRITES=4, spr_active=4'b0101, each sprite models 13 pixels and then done → start pulses in order: 0, 2 (spr_erase=1); then 0, 2 (spr_erase=0). 52 vga_plot pulses total. Erase-pass vga_colour=000. Draw pass carries sprite colours (e.g. 3'b110). busy drops afterwards.
3. spr_active=4'b0000, tick → busy high for exactly 8 cycles, then 0. No spr_start, no vga_plot.
4. Tick while busy (sprite 0 still drawing) → frame_overrun one-cycle pulse. The sequence completes unchanged and no second sequence starts.
5. Stale done: sprite 1 holds spr_done=1 before its grant → scheduler stays in WAIT for at least 2 cycles. It advances only on the first done sampled after the ignore window.
6. With SCHED_WATCHDOG_EN, WDOG_CYCLES=16, sprite 3 never asserts done → after 16 WAIT cycles the FSM advances and timeout_err=1, holding until reset. Without the macro, the FSM remains in WAIT and timeout_err=0.
